ecc_apb_cmd_master: RTL and testbench

Upstream driver for ecc_enc_dec. It accepts one ECC job per valid/ready handshake and issues the APB write sequence that programs and starts the job. It then waits for operation_done, captures data_out and num_of_errors, and returns them on a valid/ready response port. It replaces ad-hoc stimulus at system level and provides the single APB master in front of ecc_enc_dec.

---
 rtl/ecc_apb_cmd_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ecc_apb_cmd_master.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_cmd_master.sv
// APB command master in front of ecc_enc_dec: one job in, four APB writes out, one response back.
// Optional build macro ECC_CMD_SKIP_REDUNDANT_EN skips DATA/NOISE/CW_WIDTH writes that repeat the last value.
module ecc_apb_cmd_master #(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         AMBA_ADDR_WIDTH = 20,
    parameter int                         AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] CTRL_ADDR       = 'h00,
    parameter logic [AMBA_ADDR_WIDTH-1:0] DATA_ADDR       = 'h04,
    parameter logic [AMBA_ADDR_WIDTH-1:0] CW_WIDTH_ADDR   = 'h08,
    parameter logic [AMBA_ADDR_WIDTH-1:0] NOISE_ADDR      = 'h0C,
    parameter int                         TIMEOUT_CYCLES  = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic                       rsp_badop,
    output logic                       busy,
    output logic [2:0]                 dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and payload stable until then, and ready never depends on valid.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_ACCESS    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [1:0] WR_DATA  = 2'd0;
    localparam logic [1:0] WR_NOISE = 2'd1;
    localparam logic [1:0] WR_CW    = 2'd2;
    localparam logic [1:0] WR_CTRL  = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    logic [1:0]           wr_idx_q;
    logic [1:0]           op_q;
    logic [1:0]           width_q;
    logic [AMBA_WORD-1:0] data_q;
    logic [AMBA_WORD-1:0] noise_q;
    logic [CNT_W-1:0]     wait_cnt_q;

    logic [AMBA_WORD-1:0]       src_data;
    logic [AMBA_WORD-1:0]       src_noise;
    logic [1:0]                 src_width;
    logic [1:0]                 src_op;
    logic [1:0]                 setup_idx_d;
    logic [AMBA_ADDR_WIDTH-1:0] setup_addr_d;
    logic [AMBA_WORD-1:0]       setup_wdata_d;

`ifdef ECC_CMD_SKIP_REDUNDANT_EN
    logic [AMBA_WORD-1:0] sh_data_q;
    logic [AMBA_WORD-1:0] sh_noise_q;
    logic [1:0]           sh_width_q;
    logic                 sh_data_vld_q;
    logic                 sh_noise_vld_q;
    logic                 sh_width_vld_q;
`endif

    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    // Pick the next write to issue: from IDLE it starts the sequence using the live command,
    // from ACCESS it continues after the current write using the latched command.
    always_comb begin
        src_data      = data_q;
        src_noise     = noise_q;
        src_width     = width_q;
        src_op        = op_q;
        setup_idx_d   = wr_idx_q + 2'd1;
        setup_addr_d  = CTRL_ADDR;
        setup_wdata_d = '0;
        if (state_q == S_IDLE) begin
            src_data    = cmd_data;
            src_noise   = cmd_noise;
            src_width   = cmd_width;
            src_op      = cmd_op;
            setup_idx_d = WR_DATA;
        end
`ifdef ECC_CMD_SKIP_REDUNDANT_EN
        if (setup_idx_d == WR_DATA && sh_data_vld_q && sh_data_q == src_data)
            setup_idx_d = WR_NOISE;
        if (setup_idx_d == WR_NOISE && sh_noise_vld_q && sh_noise_q == src_noise)
            setup_idx_d = WR_CW;
        if (setup_idx_d == WR_CW && sh_width_vld_q && sh_width_q == src_width)
            setup_idx_d = WR_CTRL;
`endif
        case (setup_idx_d)
            WR_DATA: begin
                setup_addr_d  = DATA_ADDR;
                setup_wdata_d = src_data;
            end
            WR_NOISE: begin
                setup_addr_d  = NOISE_ADDR;
                setup_wdata_d = src_noise;
            end
            WR_CW: begin
                setup_addr_d  = CW_WIDTH_ADDR;
                setup_wdata_d = {{(AMBA_WORD-2){1'b0}}, src_width};
            end
            default: begin
                setup_addr_d  = CTRL_ADDR;
                setup_wdata_d = {{(AMBA_WORD-2){1'b0}}, src_op};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_idx_q    <= WR_DATA;
            op_q        <= '0;
            width_q     <= '0;
            data_q      <= '0;
            noise_q     <= '0;
            wait_cnt_q  <= '0;
            cmd_ready   <= 1'b1;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_errors  <= '0;
            rsp_timeout <= 1'b0;
            rsp_badop   <= 1'b0;
`ifdef ECC_CMD_SKIP_REDUNDANT_EN
            sh_data_q      <= '0;
            sh_noise_q     <= '0;
            sh_width_q     <= '0;
            sh_data_vld_q  <= 1'b0;
            sh_noise_vld_q <= 1'b0;
            sh_width_vld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        width_q     <= cmd_width;
                        data_q      <= cmd_data;
                        noise_q     <= cmd_noise;
                        cmd_ready   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_badop   <= 1'b0;
                        if (cmd_op == 2'd3) begin
                            state_q    <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_badop  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_errors <= '0;
                        end else begin
                            state_q  <= S_SETUP;
                            wr_idx_q <= setup_idx_d;
                            PSEL     <= 1'b1;
                            PENABLE  <= 1'b0;
                            PWRITE   <= 1'b1;
                            PADDR    <= setup_addr_d;
                            PWDATA   <= setup_wdata_d;
                        end
                    end
                end
                S_SETUP: begin
                    state_q <= S_ACCESS;
                    PENABLE <= 1'b1;
                end
                S_ACCESS: begin
`ifdef ECC_CMD_SKIP_REDUNDANT_EN
                    case (wr_idx_q)
                        WR_DATA: begin
                            sh_data_q     <= data_q;
                            sh_data_vld_q <= 1'b1;
                        end
                        WR_NOISE: begin
                            sh_noise_q     <= noise_q;
                            sh_noise_vld_q <= 1'b1;
                        end
                        WR_CW: begin
                            sh_width_q     <= width_q;
                            sh_width_vld_q <= 1'b1;
                        end
                        default: ;
                    endcase
`endif
                    if (wr_idx_q == WR_CTRL) begin
                        state_q    <= S_WAIT_DONE;
                        wait_cnt_q <= '0;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        PWRITE     <= 1'b0;
                        PADDR      <= '0;
                        PWDATA     <= '0;
                    end else begin
                        state_q  <= S_SETUP;
                        wr_idx_q <= setup_idx_d;
                        PENABLE  <= 1'b0;
                        PADDR    <= setup_addr_d;
                        PWDATA   <= setup_wdata_d;
                    end
                end
                S_WAIT_DONE: begin
                    // A done arriving on the last permitted cycle still counts as a completion.
                    if (operation_done) begin
                        state_q     <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= data_out;
                        rsp_errors  <= num_of_errors;
                        rsp_timeout <= 1'b0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q     <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_errors  <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PWRITE    <= 1'b0;
                    PADDR     <= '0;
                    PWDATA    <= '0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
// Directed self-checking bench for ecc_apb_cmd_master; the ecc_enc_dec side is driven by hand.
module tb_ecc_apb_cmd_master;

    localparam int AW = 20;
    localparam int WW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [1:0]    cmd_width = '0;
    logic [WW-1:0] cmd_data = '0;
    logic [WW-1:0] cmd_noise = '0;
    logic [AW-1:0] PADDR;
    logic [WW-1:0] PWDATA;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic          operation_done = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic [1:0]    num_of_errors = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_errors;
    logic          rsp_timeout;
    logic          rsp_badop;
    logic          busy;
    logic [2:0]    dbg_state_o;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int protocol_err = 0;

    logic [AW+WW-1:0] apb_log[$];
    logic [AW+WW-1:0] exp_q[$];

    ecc_apb_cmd_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_width(cmd_width),
        .cmd_data(cmd_data), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
        .rsp_timeout(rsp_timeout), .rsp_badop(rsp_badop), .busy(busy), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // APB monitor: logs every ACCESS and counts protocol violations.
    logic          setup_seen = 1'b0;
    logic [AW-1:0] setup_addr;
    logic [WW-1:0] setup_data;
    always @(posedge clk) begin
        #1;
        if (PSEL && !PENABLE) begin
            if (setup_seen || !PWRITE) protocol_err++;
            setup_seen = 1'b1;
            setup_addr = PADDR;
            setup_data = PWDATA;
        end else if (PSEL && PENABLE) begin
            if (!setup_seen || PADDR !== setup_addr || PWDATA !== setup_data || !PWRITE)
                protocol_err++;
            apb_log.push_back({PADDR, PWDATA});
            setup_seen = 1'b0;
        end else begin
            if (PENABLE) protocol_err++;
            setup_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] width,
                            input logic [WW-1:0] data, input logic [WW-1:0] noise,
                            output bit ok);
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_width = width;
        cmd_data  = data;
        cmd_noise = noise;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for WAIT_DONE, pulses done, and consumes the response.
    task automatic finish_job(input logic [DW-1:0] d, input logic [1:0] e, output bit ok);
        bit got;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dbg_state_o == 3'd3) break;
            tick();
        end
        if (dbg_state_o != 3'd3) return;
        operation_done = 1'b1;
        data_out       = d;
        num_of_errors  = e;
        tick();
        operation_done = 1'b0;
        wait_rsp(5, got);
        if (!got) return;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        check_cnt++;
        if ({cmd_ready, busy, rsp_valid, PSEL, PENABLE, PWRITE} !== 6'b100000)
            $display("FAIL reset_ctrl actual=%b expected=100000", {cmd_ready, busy, rsp_valid, PSEL, PENABLE, PWRITE});
        else pass_cnt++;
        check_cnt++;
        if (PADDR !== '0 || PWDATA !== '0 || rsp_data !== '0 || rsp_errors !== '0 || rsp_timeout !== 1'b0 || rsp_badop !== 1'b0)
            $display("FAIL reset_data actual=%h/%h/%h/%b/%b/%b expected=all zero", PADDR, PWDATA, rsp_data, rsp_errors, rsp_timeout, rsp_badop);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_encode();
        bit ok;
        apb_log.delete();
        exp_q.delete();
        exp_q.push_back({20'h04, 32'h000000A5});
        exp_q.push_back({20'h0C, 32'h00000000});
        exp_q.push_back({20'h08, 32'h00000000});
        exp_q.push_back({20'h00, 32'h00000000});
        send_cmd(2'd0, 2'd0, 32'hA5, 32'h0, ok);
        check_cnt++;
        if (!ok) $display("FAIL enc_accept actual=no handshake expected=handshake");
        else pass_cnt++;
        check_cnt++;
        if ({PSEL, PENABLE, PWRITE, busy, cmd_ready} !== 5'b10110 || PADDR !== 20'h04 || PWDATA !== 32'hA5)
            $display("FAIL enc_cycle1 actual=%b addr=%h data=%h expected=10110 addr=04 data=a5", {PSEL, PENABLE, PWRITE, busy, cmd_ready}, PADDR, PWDATA);
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'h04)
            $display("FAIL enc_cycle2 actual=%b addr=%h expected=11 addr=04", {PSEL, PENABLE}, PADDR);
        else pass_cnt++;
        repeat (6) tick();
        check_cnt++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'h00 || PWDATA !== 32'h0)
            $display("FAIL enc_ctrl_cycle8 actual=%b addr=%h data=%h expected=11 addr=00 data=0", {PSEL, PENABLE}, PADDR, PWDATA);
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, busy} !== 5'b00001 || PADDR !== '0 || PWDATA !== '0)
            $display("FAIL enc_wait_cycle9 actual=%b addr=%h expected=00001 addr=0", {PSEL, PENABLE, PWRITE, rsp_valid, busy}, PADDR);
        else pass_cnt++;
        check_cnt++;
        if (apb_log.size() != exp_q.size())
            $display("FAIL enc_log_size actual=%0d expected=%0d", apb_log.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < apb_log.size(); i++) begin
            check_cnt++;
            if (apb_log[i] !== exp_q[i])
                $display("FAIL enc_log_%0d actual=%h expected=%h", i, apb_log[i], exp_q[i]);
            else pass_cnt++;
        end
        operation_done = 1'b1;
        data_out       = 32'h1A5;
        num_of_errors  = 2'd0;
        tick();
        operation_done = 1'b0;
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1A5 || rsp_errors !== 2'd0 || rsp_timeout !== 1'b0 || rsp_badop !== 1'b0)
            $display("FAIL enc_rsp actual=v%b d=%h e=%0d t=%b b=%b expected=v1 d=1a5 e=0 t0 b0", rsp_valid, rsp_data, rsp_errors, rsp_timeout, rsp_badop);
        else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_cnt++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010)
            $display("FAIL enc_after_rsp actual=%b expected=010", {rsp_valid, cmd_ready, busy});
        else pass_cnt++;
    endtask

    task automatic test_decode_hold();
        bit ok;
        apb_log.delete();
        exp_q.delete();
        exp_q.push_back({20'h04, 32'h12345678});
        exp_q.push_back({20'h0C, 32'h00000004});
        exp_q.push_back({20'h08, 32'h00000002});
        exp_q.push_back({20'h00, 32'h00000001});
        send_cmd(2'd1, 2'd2, 32'h12345678, 32'h4, ok);
        repeat (7) tick();
        check_cnt++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'h00 || PWDATA !== 32'h1)
            $display("FAIL dec_ctrl actual=%b addr=%h data=%h expected=11 addr=00 data=1", {PSEL, PENABLE}, PADDR, PWDATA);
        else pass_cnt++;
        repeat (5) tick();
        operation_done = 1'b1;
        data_out       = 32'hDEADBEEF;
        num_of_errors  = 2'd1;
        tick();
        operation_done = 1'b0;
        data_out       = 32'h0;
        num_of_errors  = 2'd0;
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_errors !== 2'd1 || rsp_timeout !== 1'b0)
            $display("FAIL dec_rsp actual=v%b d=%h e=%0d t=%b expected=v1 d=deadbeef e=1 t0", rsp_valid, rsp_data, rsp_errors, rsp_timeout);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            operation_done = (i == 1);
            tick();
            check_cnt++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_errors !== 2'd1)
                $display("FAIL dec_hold_%0d actual=v%b d=%h e=%0d expected=v1 d=deadbeef e=1", i, rsp_valid, rsp_data, rsp_errors);
            else pass_cnt++;
        end
        operation_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_cnt++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL dec_release actual=v%b r%b expected=v0 r1", rsp_valid, cmd_ready);
        else pass_cnt++;
        check_cnt++;
        if (apb_log.size() != 4 || apb_log[0] !== exp_q[0] || apb_log[1] !== exp_q[1] || apb_log[2] !== exp_q[2] || apb_log[3] !== exp_q[3])
            $display("FAIL dec_log actual_size=%0d expected=4 writes 04,0C,08,00", apb_log.size());
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok;
        // Never-done job: WAIT_DONE entered at cycle 9, response 1023 cycles later.
        data_out = 32'hFFFF;
        send_cmd(2'd0, 2'd1, 32'h1, 32'h2, ok);
        repeat (8) tick();
        check_cnt++;
        if (dbg_state_o !== 3'd3)
            $display("FAIL to_enter_wait actual=%0d expected=3", dbg_state_o);
        else pass_cnt++;
        repeat (1022) tick();
        check_cnt++;
        if (rsp_valid !== 1'b0)
            $display("FAIL to_early actual=%b expected=0", rsp_valid);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== '0 || rsp_errors !== '0)
            $display("FAIL to_rsp actual=v%b t%b d=%h e=%0d expected=v1 t1 d=0 e=0", rsp_valid, rsp_timeout, rsp_data, rsp_errors);
        else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // Done on the last permitted cycle beats the timeout.
        send_cmd(2'd2, 2'd0, 32'h3, 32'h5, ok);
        check_cnt++;
        if (rsp_timeout !== 1'b0)
            $display("FAIL to_clear_on_accept actual=%b expected=0", rsp_timeout);
        else pass_cnt++;
        repeat (8 + 1022) tick();
        operation_done = 1'b1;
        data_out       = 32'h55;
        num_of_errors  = 2'd2;
        tick();
        operation_done = 1'b0;
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== 32'h55 || rsp_errors !== 2'd2)
            $display("FAIL to_done_wins actual=v%b t%b d=%h e=%0d expected=v1 t0 d=55 e=2", rsp_valid, rsp_timeout, rsp_data, rsp_errors);
        else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        data_out = '0;
        num_of_errors = '0;
    endtask

    task automatic test_badop();
        bit ok;
        apb_log.delete();
        send_cmd(2'd3, 2'd1, 32'hCAFE, 32'h9, ok);
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_badop !== 1'b1 || rsp_data !== '0 || rsp_errors !== '0 || rsp_timeout !== 1'b0 || PSEL !== 1'b0)
            $display("FAIL badop_rsp actual=v%b b%b d=%h e=%0d t%b psel%b expected=v1 b1 d=0 e=0 t0 psel0", rsp_valid, rsp_badop, rsp_data, rsp_errors, rsp_timeout, PSEL);
        else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        check_cnt++;
        if (apb_log.size() != 0)
            $display("FAIL badop_no_apb actual=%0d expected=0", apb_log.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        send_cmd(2'd0, 2'd0, 32'h11, 32'h22, ok);
        check_cnt++;
        if (rsp_badop !== 1'b0)
            $display("FAIL mid_badop_cleared actual=%b expected=0", rsp_badop);
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'h0C)
            $display("FAIL mid_noise_access actual=%b addr=%h expected=11 addr=0c", {PSEL, PENABLE}, PADDR);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cnt++;
        if ({PSEL, PENABLE, busy, cmd_ready} !== 4'b0001)
            $display("FAIL mid_reset_edge actual=%b expected=0001", {PSEL, PENABLE, busy, cmd_ready});
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            operation_done = (i % 7 == 3);
            tick();
            if (rsp_valid || PSEL) seen++;
        end
        operation_done = 1'b0;
        check_cnt++;
        if (seen != 0)
            $display("FAIL mid_no_activity actual=%0d expected=0", seen);
        else pass_cnt++;
        apb_log.delete();
        send_cmd(2'd0, 2'd0, 32'h11, 32'h22, ok);
        finish_job(32'h7, 2'd0, ok);
        check_cnt++;
        if (!ok) $display("FAIL mid_next_job actual=incomplete expected=complete");
        else pass_cnt++;
        check_cnt++;
        if (apb_log.size() != 4)
            $display("FAIL mid_next_writes actual=%0d expected=4", apb_log.size());
        else pass_cnt++;
    endtask

`ifdef ECC_CMD_SKIP_REDUNDANT_EN
    task automatic test_skip_redundant();
        bit ok;
        send_cmd(2'd2, 2'd1, 32'h77, 32'h1, ok);
        finish_job(32'h1, 2'd0, ok);
        apb_log.delete();
        send_cmd(2'd2, 2'd1, 32'h77, 32'h1, ok);
        check_cnt++;
        if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 20'h00 || PWDATA !== 32'h2)
            $display("FAIL skip_ctrl_first actual=%b addr=%h data=%h expected=10 addr=00 data=2", {PSEL, PENABLE}, PADDR, PWDATA);
        else pass_cnt++;
        repeat (2) tick();
        check_cnt++;
        if (dbg_state_o !== 3'd3)
            $display("FAIL skip_wait_cycle3 actual=%0d expected=3", dbg_state_o);
        else pass_cnt++;
        finish_job(32'h2, 2'd0, ok);
        check_cnt++;
        if (apb_log.size() != 1 || apb_log[0] !== {20'h00, 32'h2})
            $display("FAIL skip_repeat_log actual_size=%0d expected=1 write 00<=2", apb_log.size());
        else pass_cnt++;
        apb_log.delete();
        send_cmd(2'd2, 2'd1, 32'h77, 32'h3, ok);
        finish_job(32'h3, 2'd0, ok);
        check_cnt++;
        if (apb_log.size() != 2 || apb_log[0] !== {20'h0C, 32'h3} || apb_log[1] !== {20'h00, 32'h2})
            $display("FAIL skip_noise_log actual_size=%0d expected=2 writes 0C<=3,00<=2", apb_log.size());
        else pass_cnt++;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_encode();
        test_decode_hold();
        test_timeout();
        test_badop();
        test_reset_mid();
`ifdef ECC_CMD_SKIP_REDUNDANT_EN
        test_skip_redundant();
`endif
        check_cnt++;
        if (protocol_err != 0)
            $display("FAIL apb_protocol actual=%0d violations expected=0", protocol_err);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
